// File: rtl/adc_readout_sched.sv
// adc_readout_sched: round-robin scheduler moving BLOCK_WORDS-word bursts from two FIFOs to a host sink
// Ports: clk, rst (sync, active-high); en and sink_ready gate new grants only;
//   fN_rd_cnt/fN_empty/fN_valid/fN_data come from FIFO N, fN_rd_en goes back to it;
//   out_valid/out_data/out_src/out_last form the registered word stream;
//   busy (not IDLE), blk_cnt (completed blocks, wraps), err_underrun (sticky until rst).
module adc_readout_sched #(
    parameter int BLOCK_WORDS = 16,
    parameter int DRAIN_TO    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sink_ready,
    input  logic [6:0]   f0_rd_cnt,
    input  logic [6:0]   f1_rd_cnt,
    input  logic         f0_empty,
    input  logic         f1_empty,
    input  logic         f0_valid,
    input  logic         f1_valid,
    input  logic [255:0] f0_data,
    input  logic [255:0] f1_data,
    output logic         f0_rd_en,
    output logic         f1_rd_en,
    output logic         out_valid,
    output logic [255:0] out_data,
    output logic         out_src,
    output logic         out_last,
    output logic         busy,
    output logic [15:0]  blk_cnt,
    output logic         err_underrun
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    localparam logic [6:0]  BW  = 7'(BLOCK_WORDS);
    localparam logic [15:0] DTO = 16'(DRAIN_TO - 1);
    state_t       state, state_nx;
    logic         last_grant, elig0, elig1, grant_ok, grant_src;
    logic         in_valid, accept, done, timeout;
    logic [255:0] in_data;
    logic [6:0]   rd_cnt, rcv_cnt;
    logic [15:0]  drain_cnt;
    // out_src doubles as the grant register: it is loaded on grant and held
    // until the next grant, so it also selects the FIFO being read.
    always_comb begin
        elig0     = en && !f0_empty && f0_rd_cnt >= BW;
        elig1     = en && !f1_empty && f1_rd_cnt >= BW;
        grant_ok  = sink_ready && (elig0 || elig1);
        grant_src = (elig0 && elig1) ? !last_grant : elig1;
        in_valid  = out_src ? f1_valid : f0_valid;
        in_data   = out_src ? f1_data : f0_data;
        accept    = state != IDLE && in_valid && rcv_cnt < BW;
        done      = state == DRAIN && rcv_cnt == BW;
        timeout   = state == DRAIN && !done && drain_cnt == DTO;
        state_nx  = (state == IDLE)  ? (grant_ok ? BURST : IDLE) :
                    (state == BURST) ? ((rd_cnt == BW - 7'd1) ? DRAIN : BURST) :
                    ((done || timeout) ? IDLE : DRAIN);
        f0_rd_en  = state == BURST && !out_src;
        f1_rd_en  = state == BURST && out_src;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            out_src      <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            rd_cnt       <= '0;
            rcv_cnt      <= '0;
            drain_cnt    <= '0;
            blk_cnt      <= '0;
            err_underrun <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= accept;
            out_last  <= accept && rcv_cnt == BW - 7'd1;
            if (accept) begin
                out_data <= in_data;
                rcv_cnt  <= rcv_cnt + 7'd1;
            end
            if (state == IDLE && grant_ok) begin
                out_src   <= grant_src;
                rd_cnt    <= '0;
                rcv_cnt   <= '0;
                drain_cnt <= '0;
            end
            if (state == BURST) rd_cnt <= rd_cnt + 7'd1;
            if (state == DRAIN) drain_cnt <= drain_cnt + 16'd1;
            if (done) begin
                blk_cnt    <= blk_cnt + 16'd1;
                last_grant <= out_src;
            end
            if (timeout) err_underrun <= 1'b1;
        end
    end
endmodule
